// File: rtl/seg_display_arbiter.sv
// Shares one 8-digit seven-segment display between prioritized requesters.
// It converts the granted binary value to packed BCD with a double-dabble that processes one bit per cycle.
module seg_display_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 24,
  parameter int HOLD_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic [31:0]               bcd_out,
  output logic                      bcd_valid
);

  localparam int SR_W   = DATA_W + 32;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [SR_W-1:0]     shift_reg, shift_next;
  logic [CNT_W-1:0]    shift_cnt;
  logic [HOLD_W-1:0]   hold;
  logic                win_valid;
  logic [1:0]          win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                conv_done;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int k = 0; k < 8; k++) begin
      if (t[DATA_W+4*k +: 4] >= 4'd5)
        t[DATA_W+4*k +: 4] = t[DATA_W+4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign shift_next = dabble_step(shift_reg);
  assign conv_done  = (state == CONVERT) && (shift_cnt == LAST_SHIFT);
  assign busy       = (state == CONVERT);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    gnt        = '0;
    win_valid  = 1'b0;
    win_idx    = '0;
    win_data   = '0;
    state_next = state;
    // Scanning from the top down lets the lowest eligible index overwrite the others.
    if (state != CONVERT) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req[i] && (state == IDLE || hold == '0 || 2'(i) == owner)) begin
          gnt       = '0;
          gnt[i]    = 1'b1;
          win_valid = 1'b1;
          win_idx   = 2'(i);
          win_data  = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    case (state)
      IDLE, SHOW: if (win_valid) state_next = CONVERT;
      CONVERT:    if (conv_done) state_next = SHOW;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    if (rst) begin
      owner     <= '0;
      hold      <= '0;
      shift_reg <= '0;
      shift_cnt <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (state == SHOW && hold != '0)
        hold <= hold - 1'b1;
      if (win_valid) begin
        owner     <= win_idx;
        shift_reg <= {32'b0, win_data};
        shift_cnt <= '0;
      end else if (state == CONVERT) begin
        shift_reg <= shift_next;
        shift_cnt <= shift_cnt + 1'b1;
        // The final shift result goes straight to bcd_out, so the display never shows a partial value.
        if (conv_done) begin
          bcd_out   <= shift_next[SR_W-1 -: 32];
          bcd_valid <= 1'b1;
          hold      <= HOLD_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus randomized transfers.
// Expected values come from a decimal-digit BCD model and the hold/priority rules.
module tb_seg_display_arbiter;

  localparam int NR    = 3;
  localparam int DW    = 24;
  localparam int HC    = 16;
  localparam int BOUND = 4 * HC + 2 * DW + 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic [1:0]        owner;
  logic              busy;
  logic [31:0]       bcd_out;
  logic              bcd_valid;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_bcd;

  seg_display_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .owner(owner), .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input longint unsigned v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_bcd = '0;
  endtask

  // Requests one conversion, then checks grant timing, latency, steadiness and the result.
  // It returns in the bcd_valid cycle.
  task automatic do_transfer(input int idx, input logic [DW-1:0] data, input int exp_wait,
                             input string name);
    int            w;
    int            lat;
    bit            unsteady;
    logic [NR-1:0] exp_g;
    exp_g = '0;
    exp_g[idx] = 1'b1;
    req_data[idx*DW +: DW] = data;
    req[idx] = 1'b1;
    #1;
    w = 0;
    while (gnt === '0 && w < BOUND) begin
      step();
      w++;
    end
    n_cmp++;
    if (w !== exp_wait) begin
      n_err++;
      $display("FAIL %s grant_wait: got %0d cycles, expected %0d", name, w, exp_wait);
    end
    n_cmp++;
    if (gnt !== exp_g) begin
      n_err++;
      $display("FAIL %s gnt: got %b, expected %b", name, gnt, exp_g);
    end
    step();
    req[idx] = 1'b0;
    lat = 1;
    unsteady = 1'b0;
    while (bcd_valid !== 1'b1 && lat < BOUND) begin
      if (bcd_out !== exp_bcd || busy !== 1'b1 || gnt !== '0) unsteady = 1'b1;
      step();
      lat++;
    end
    n_cmp++;
    if (lat !== DW + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, DW + 1);
    end
    n_cmp++;
    if (unsteady !== 1'b0) begin
      n_err++;
      $display("FAIL %s convert_steady: got %0d, expected 0", name, unsteady);
    end
    exp_bcd = to_bcd(longint'(data));
    n_cmp++;
    if (bcd_out !== exp_bcd) begin
      n_err++;
      $display("FAIL %s bcd_out: got %h, expected %h", name, bcd_out, exp_bcd);
    end
    n_cmp++;
    if (owner !== 2'(idx) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s owner/busy: got %0d/%0b, expected %0d/0", name, owner, busy, idx);
    end
  endtask

  task automatic test_reset();
    bit active;
    pulse_reset();
    n_cmp++;
    if (gnt !== '0 || owner !== 2'd0 || busy !== 1'b0 || bcd_out !== 32'h0 || bcd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b owner=%0d busy=%b bcd=%h valid=%b, expected all 0",
               gnt, owner, busy, bcd_out, bcd_valid);
    end
    active = 1'b0;
    repeat (6) begin
      step();
      if (gnt !== '0 || busy !== 1'b0 || bcd_valid !== 1'b0) active = 1'b1;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: got activity %0d, expected 0", active);
    end
  endtask

  task automatic test_single();
    do_transfer(1, 24'd123456, 0, "single");
    n_cmp++;
    if (bcd_out !== 32'h00123456) begin
      n_err++;
      $display("FAIL single_value: got %h, expected 00123456", bcd_out);
    end
    step();
    n_cmp++;
    if (bcd_valid !== 1'b0 || bcd_out !== 32'h00123456) begin
      n_err++;
      $display("FAIL valid_pulse: got valid=%b bcd=%h, expected 0/00123456", bcd_valid, bcd_out);
    end
  endtask

  task automatic test_priority_hold();
    pulse_reset();
    req[2] = 1'b1;
    req_data[2*DW +: DW] = 24'd99;
    do_transfer(0, 24'd7, 0, "prio_first");
    n_cmp++;
    if (bcd_out !== 32'h00000007) begin
      n_err++;
      $display("FAIL prio_value0: got %h, expected 00000007", bcd_out);
    end
    do_transfer(2, 24'd99, HC - 1, "prio_second");
    n_cmp++;
    if (bcd_out !== 32'h00000099) begin
      n_err++;
      $display("FAIL prio_value2: got %h, expected 00000099", bcd_out);
    end
  endtask

  task automatic test_extremes();
    do_transfer(2, 24'hFFFFFF, 0, "all_ones");
    n_cmp++;
    if (bcd_out !== 32'h16777215) begin
      n_err++;
      $display("FAIL all_ones_value: got %h, expected 16777215", bcd_out);
    end
    do_transfer(2, 24'd0, 0, "zero");
    n_cmp++;
    if (bcd_out !== 32'h00000000) begin
      n_err++;
      $display("FAIL zero_value: got %h, expected 00000000", bcd_out);
    end
  endtask

  task automatic test_owner_regrant();
    logic [DW-1:0] d1;
    bit            early;
    pulse_reset();
    do_transfer(0, DW'($urandom_range(1, 999999)), 0, "regrant_setup");
    d1 = DW'($urandom_range(1, 16777215));
    req_data[DW +: DW] = d1;
    req[1] = 1'b1;
    early = 1'b0;
    repeat (5) begin
      step();
      if (gnt !== '0) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++;
      $display("FAIL regrant_blocked: got early grant %0d, expected 0", early);
    end
    do_transfer(0, 24'd42, 0, "regrant_owner");
    n_cmp++;
    if (bcd_out !== 32'h00000042) begin
      n_err++;
      $display("FAIL regrant_value: got %h, expected 00000042", bcd_out);
    end
    do_transfer(1, d1, HC - 1, "regrant_other");
  endtask

  task automatic test_reset_midconvert();
    bit seen;
    req_data[DW +: DW] = DW'($urandom_range(1, 16777215));
    req[1] = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_err++;
      $display("FAIL abort_gnt: got %b, expected 010", gnt);
    end
    step();
    req[1] = 1'b0;
    repeat (9) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_busy_before: got %b, expected 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_bcd = '0;
    n_cmp++;
    if (busy !== 1'b0 || bcd_out !== 32'h0 || bcd_valid !== 1'b0 || owner !== 2'd0) begin
      n_err++;
      $display("FAIL abort_state: got busy=%b bcd=%h valid=%b owner=%0d, expected 0/0/0/0",
               busy, bcd_out, bcd_valid, owner);
    end
    seen = 1'b0;
    repeat (DW + 4) begin
      if (bcd_valid === 1'b1) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_valid: got %0d, expected 0", seen);
    end
    do_transfer(2, DW'($urandom), 0, "after_abort");
  endtask

  task automatic test_random();
    int cur_owner;
    int idx;
    int exp_wait;
    pulse_reset();
    cur_owner = -1;
    for (int n = 0; n < 12; n++) begin
      idx = int'($urandom_range(0, NR - 1));
      exp_wait = (cur_owner < 0 || idx == cur_owner) ? 0 : HC - 1;
      do_transfer(idx, DW'($urandom), exp_wait, "random");
      cur_owner = idx;
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    exp_bcd  = '0;
    test_reset();
    test_single();
    test_priority_hold();
    test_extremes();
    test_owner_regrant();
    test_reset_midconvert();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
